// File: rtl/broadcast_sender_if.sv
// Upstream datagram port of the broadcast transmitter.
// The producer offers one datagram plus a channel mask with in_valid. The
// transmitter answers with in_ready while it is idle, and a datagram is
// taken on any cycle where both are high.
//   in_valid   producer -> sender   datagram offered
//   in_ready   sender -> producer   sender idle, offer will be accepted
//   in_data    producer -> sender   MSG_W-bit datagram
//   ch_enable  producer -> sender   N_CH-bit channel mask for this datagram
interface broadcast_sender_if #(
  parameter int N_CH  = 4,
  parameter int MSG_W = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [MSG_W-1:0] in_data;
  logic [N_CH-1:0]  ch_enable;

  modport master (output in_valid, output in_data, output ch_enable, input in_ready);
  modport slave  (input in_valid, input in_data, input ch_enable, output in_ready);
endinterface

// File: rtl/broadcast_sender.sv
// N-channel broadcast transmitter.
// Takes one datagram from the upstream interface and sends it, lowest chunk
// first, on every channel enabled in the mask. Each channel runs its own
// 4-phase REQ/ACK handshake. If a channel waits too long in any phase it is
// flagged in ch_err and dropped, and the other channels carry on. A single
// done pulse marks the point where every channel has finished or faulted.
//   clk        system clock
//   rst        asynchronous reset, active-high
//   up         upstream datagram port (in_valid/in_ready/in_data/ch_enable)
//   ack        per-channel ACK from remote receivers, asynchronous to clk
//   req        per-channel REQ
//   dout       per-channel chunk, channel g on [g*CHUNK_W +: CHUNK_W]
//   busy       broadcast in progress
//   done       one-cycle pulse when the broadcast completes
//   ch_err     sticky per-channel timeout flag, cleared at the next accept
module broadcast_sender #(
  parameter int N_CH    = 4,
  parameter int MSG_W   = 32,
  parameter int CHUNK_W = 6,
  parameter int TIMEOUT = 1024
) (
  input  logic                    clk,
  input  logic                    rst,
  broadcast_sender_if.slave       up,
  input  logic [N_CH-1:0]         ack,
  output logic [N_CH-1:0]         req,
  output logic [N_CH*CHUNK_W-1:0] dout,
  output logic                    busy,
  output logic                    done,
  output logic [N_CH-1:0]         ch_err
);

  localparam int NCHUNK = (MSG_W + CHUNK_W - 1) / CHUNK_W;
  localparam int PAD_W  = NCHUNK * CHUNK_W;
  localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam int TC_W   = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCHUNK - 1);
  localparam logic [TC_W-1:0]  TC_MAX   = TC_W'(TIMEOUT - 1);

  typedef enum logic {G_IDLE, G_BUSY} g_state_t;
  typedef enum logic [2:0] {
    CH_IDLE, CH_SETUP, CH_REQH, CH_REQL, CH_DONE, CH_ERR
  } ch_state_t;

  g_state_t         g_state;
  ch_state_t        ch_state [N_CH];
  logic [IDX_W-1:0] idx      [N_CH];
  logic [TC_W-1:0]  tcnt     [N_CH];

  logic [PAD_W-1:0]   shadow;
  logic [PAD_W-1:0]   in_pad;
  logic [CHUNK_W-1:0] chunks     [NCHUNK];
  logic [CHUNK_W-1:0] next_chunk [N_CH];
  logic [N_CH-1:0]    ack_m;
  logic [N_CH-1:0]    ack_s;
  logic               accept;
  logic               all_fin;

  assign up.in_ready = !rst && (g_state == G_IDLE);
  assign accept      = up.in_valid && up.in_ready;
  assign busy        = (g_state == G_BUSY);
  // done decodes registered state: it is high on the last BUSY cycle, and the
  // FSM returns to idle on the following edge.
  assign done        = busy && all_fin;

  // Pad the datagram up to a whole number of chunks. The extra MSBs read as 0.
  always_comb begin
    in_pad = '0;
    in_pad[MSG_W-1:0] = up.in_data;
  end

  always_comb begin
    for (int k = 0; k < NCHUNK; k++) begin
      chunks[k] = shadow[k*CHUNK_W +: CHUNK_W];
    end
  end

  // Chunk that a channel loads when it moves on from its current index.
  always_comb begin
    for (int g = 0; g < N_CH; g++) begin
      next_chunk[g] = chunks[0];
      if (idx[g] != LAST_IDX) begin
        next_chunk[g] = chunks[idx[g] + IDX_W'(1)];
      end
    end
  end

  always_comb begin
    all_fin = 1'b1;
    for (int g = 0; g < N_CH; g++) begin
      if (ch_state[g] != CH_DONE && ch_state[g] != CH_ERR) begin
        all_fin = 1'b0;
      end
    end
  end

  // Two-flop synchroniser for the asynchronous ACK lines.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ack_m <= '0;
      ack_s <= '0;
    end else begin
      ack_m <= ack;
      ack_s <= ack_m;
    end
  end

  // Global FSM and all channel FSMs.
  // In every waiting state the awaited ACK level is tested before the
  // timeout, so ACK wins if both happen in the same cycle. The first chunk is
  // loaded straight from in_data on the accept edge, because the shadow copy
  // only becomes valid one cycle later.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      g_state <= G_IDLE;
      shadow  <= '0;
      ch_err  <= '0;
      req     <= '0;
      dout    <= '0;
      for (int g = 0; g < N_CH; g++) begin
        ch_state[g] <= CH_IDLE;
        idx[g]      <= '0;
        tcnt[g]     <= '0;
      end
    end else begin
      case (g_state)
        G_IDLE: begin
          if (accept) begin
            g_state <= G_BUSY;
            shadow  <= in_pad;
            ch_err  <= '0;
          end
        end
        G_BUSY: begin
          if (all_fin) begin
            g_state <= G_IDLE;
          end
        end
        default: g_state <= G_IDLE;
      endcase

      for (int g = 0; g < N_CH; g++) begin
        case (ch_state[g])
          CH_IDLE: begin
            if (accept) begin
              if (up.ch_enable[g]) begin
                ch_state[g]                <= CH_SETUP;
                idx[g]                     <= '0;
                tcnt[g]                    <= '0;
                dout[g*CHUNK_W +: CHUNK_W] <= in_pad[CHUNK_W-1:0];
              end else begin
                ch_state[g] <= CH_DONE;
              end
            end
          end
          CH_SETUP: begin
            if (!ack_s[g]) begin
              ch_state[g] <= CH_REQH;
              req[g]      <= 1'b1;
              tcnt[g]     <= '0;
            end else if (tcnt[g] == TC_MAX) begin
              ch_state[g] <= CH_ERR;
              ch_err[g]   <= 1'b1;
            end else begin
              tcnt[g] <= tcnt[g] + TC_W'(1);
            end
          end
          CH_REQH: begin
            if (ack_s[g]) begin
              ch_state[g] <= CH_REQL;
              req[g]      <= 1'b0;
              tcnt[g]     <= '0;
            end else if (tcnt[g] == TC_MAX) begin
              ch_state[g] <= CH_ERR;
              req[g]      <= 1'b0;
              ch_err[g]   <= 1'b1;
            end else begin
              tcnt[g] <= tcnt[g] + TC_W'(1);
            end
          end
          CH_REQL: begin
            if (!ack_s[g]) begin
              if (idx[g] == LAST_IDX) begin
                ch_state[g] <= CH_DONE;
              end else begin
                ch_state[g]                <= CH_SETUP;
                idx[g]                     <= idx[g] + IDX_W'(1);
                tcnt[g]                    <= '0;
                dout[g*CHUNK_W +: CHUNK_W] <= next_chunk[g];
              end
            end else if (tcnt[g] == TC_MAX) begin
              ch_state[g] <= CH_ERR;
              ch_err[g]   <= 1'b1;
            end else begin
              tcnt[g] <= tcnt[g] + TC_W'(1);
            end
          end
          CH_DONE, CH_ERR: begin
            if (g_state == G_BUSY && all_fin) begin
              ch_state[g] <= CH_IDLE;
            end
          end
          default: ch_state[g] <= CH_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_broadcast_sender.sv
// Testbench for broadcast_sender.
// Configuration: 4 channels, 16-bit datagrams, 6-bit chunks, TIMEOUT 16.
// A receiver model per channel can echo REQ, tie ACK low, tie ACK high, or
// answer each phase after a fixed delay. The stimulus pushes the expected
// chunks and the expected ch_err value into queues. A monitor process pops
// and compares one entry for every rising REQ and for every done pulse.
module tb_broadcast_sender;

  localparam int N  = 4;
  localparam int MW = 16;
  localparam int CW = 6;
  localparam int TO = 16;

  localparam int M_ECHO  = 0;
  localparam int M_ZERO  = 1;
  localparam int M_ONE   = 2;
  localparam int M_DELAY = 3;
  localparam int DLY     = 9;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [N-1:0]  ack = '0;
  logic [N-1:0]  req;
  logic [N*CW-1:0] dout;
  logic          busy;
  logic          done;
  logic [N-1:0]  ch_err;

  broadcast_sender_if #(.N_CH(N), .MSG_W(MW)) bus ();

  broadcast_sender #(.N_CH(N), .MSG_W(MW), .CHUNK_W(CW), .TIMEOUT(TO)) dut (
    .clk    (clk),
    .rst    (rst),
    .up     (bus),
    .ack    (ack),
    .req    (req),
    .dout   (dout),
    .busy   (busy),
    .done   (done),
    .ch_err (ch_err)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [CW-1:0] exp_q [N][$];
  logic [N-1:0]  done_q [$];
  int mode     [N] = '{default: 0};
  int dly_cnt  [N] = '{default: 0};
  int hi_run   [N] = '{default: 0};
  int last_hi  [N] = '{default: 0};
  int rise_cnt [N] = '{default: 0};
  logic [N-1:0] prev_req = '0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req_val);
    n_cmp++;
    if (act !== req_val) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, act, req_val);
    end
  endtask

  // Remote receiver models.
  always @(negedge clk) begin
    for (int g = 0; g < N; g++) begin
      case (mode[g])
        M_ECHO: ack[g] = req[g];
        M_ZERO: ack[g] = 1'b0;
        M_ONE:  ack[g] = 1'b1;
        default: begin
          if (ack[g] != req[g]) begin
            if (dly_cnt[g] >= DLY) begin
              ack[g] = req[g];
              dly_cnt[g] = 0;
            end else begin
              dly_cnt[g]++;
            end
          end else begin
            dly_cnt[g] = 0;
          end
        end
      endcase
    end
  end

  // Monitor: compare chunks on every rising REQ and ch_err on every done pulse.
  always @(negedge clk) begin
    logic [CW-1:0] e;
    int pending;
    if (rst) begin
      prev_req = '0;
      for (int g = 0; g < N; g++) hi_run[g] = 0;
    end else begin
      for (int g = 0; g < N; g++) begin
        if (req[g] && !prev_req[g]) begin
          rise_cnt[g]++;
          checkOutput($sformatf("ch%0d_req_expected", g), 32'(exp_q[g].size() > 0), 32'(1));
          if (exp_q[g].size() > 0) begin
            e = exp_q[g].pop_front();
            checkOutput($sformatf("ch%0d_chunk", g), 32'(dout[g*CW +: CW]), 32'(e));
          end
        end
        if (req[g]) hi_run[g]++;
        else if (hi_run[g] > 0) begin
          last_hi[g] = hi_run[g];
          hi_run[g]  = 0;
        end
      end
      prev_req = req;
      if (done) begin
        checkOutput("done_expected", 32'(done_q.size() > 0), 32'(1));
        if (done_q.size() > 0) begin
          checkOutput("ch_err_at_done", 32'(ch_err), 32'(done_q.pop_front()));
          pending = 0;
          for (int g = 0; g < N; g++) pending += exp_q[g].size();
          checkOutput("chunks_left_at_done", 32'(pending), 32'(0));
          checkOutput("in_ready_at_done", 32'(bus.in_ready), 32'(0));
        end
      end
    end
  end

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Offer one datagram. c0..c2 are the hand-computed chunks. err lists the
  // channels expected to time out; partial lists those that still present
  // chunk 0 before timing out.
  task automatic applyStimulus(input logic [MW-1:0] data, input logic [N-1:0] mask,
                               input logic [CW-1:0] c0, input logic [CW-1:0] c1,
                               input logic [CW-1:0] c2, input logic [N-1:0] err,
                               input logic [N-1:0] partial);
    int t = 0;
    while (!bus.in_ready && t < 3000) begin
      @(negedge clk);
      t++;
    end
    checkOutput("in_ready_before_accept", 32'(bus.in_ready), 32'(1));
    for (int g = 0; g < N; g++) begin
      if (mask[g] && !err[g]) begin
        exp_q[g].push_back(c0);
        exp_q[g].push_back(c1);
        exp_q[g].push_back(c2);
      end else if (mask[g] && partial[g]) begin
        exp_q[g].push_back(c0);
      end
    end
    done_q.push_back(err);
    bus.in_valid  = 1'b1;
    bus.in_data   = data;
    bus.ch_enable = mask;
    @(negedge clk);
    checkOutput("busy_after_accept", 32'(busy), 32'(1));
    bus.in_data   = ~data;
    bus.ch_enable = ~mask;
    waitCycles(2);
    bus.in_valid  = 1'b0;
  endtask

  task automatic waitDone();
    int t = 0;
    while (done_q.size() != 0 && t < 3000) begin
      @(negedge clk);
      t++;
    end
    checkOutput("done_within_budget", 32'(done_q.size()), 32'(0));
    @(negedge clk);
    checkOutput("in_ready_after_done", 32'(bus.in_ready), 32'(1));
  endtask

  initial begin
    int t;
    logic any_req;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.ch_enable = '0;

    #1;
    checkOutput("reset_req", 32'(req), 32'(0));
    checkOutput("reset_dout", 32'(dout), 32'(0));
    checkOutput("reset_busy", 32'(busy), 32'(0));
    checkOutput("reset_done", 32'(done), 32'(0));
    checkOutput("reset_ch_err", 32'(ch_err), 32'(0));
    checkOutput("reset_in_ready", 32'(bus.in_ready), 32'(0));
    waitCycles(3);
    rst = 1'b0;
    #1;
    checkOutput("in_ready_after_reset", 32'(bus.in_ready), 32'(1));

    $display("[TB] all channels, A5C3");
    applyStimulus(16'hA5C3, 4'hF, 6'h03, 6'h17, 6'h0A, 4'h0, 4'h0);
    waitDone();
    checkOutput("min_reqh_cycles", 32'(last_hi[0]), 32'(3));
    checkOutput("ch3_dout_keeps_last", 32'(dout[3*CW +: CW]), 32'(6'h0A));

    $display("[TB] mask 0101, 0001");
    applyStimulus(16'h0001, 4'b0101, 6'h01, 6'h00, 6'h00, 4'h0, 4'h0);
    waitDone();
    checkOutput("ch1_dout_untouched", 32'(dout[1*CW +: CW]), 32'(6'h0A));
    checkOutput("ch0_dout_last", 32'(dout[0*CW +: CW]), 32'(6'h00));

    $display("[TB] channel 2 ack tied low");
    mode[2] = M_ZERO;
    applyStimulus(16'hFFFF, 4'hF, 6'h3F, 6'h3F, 6'h0F, 4'b0100, 4'b0100);
    waitDone();
    checkOutput("ch2_reqh_timeout_cycles", 32'(last_hi[2]), 32'(16));
    mode[2] = M_ECHO;

    $display("[TB] channel 1 slow ack");
    mode[1] = M_DELAY;
    applyStimulus(16'h1234, 4'hF, 6'h34, 6'h08, 6'h01, 4'h0, 4'h0);
    waitDone();
    checkOutput("ch1_slow_reqh_cycles", 32'(last_hi[1]), 32'(12));
    mode[1] = M_ECHO;

    $display("[TB] channel 0 ack stuck high, then released");
    mode[0] = M_ONE;
    waitCycles(3);
    applyStimulus(16'h8001, 4'hF, 6'h01, 6'h00, 6'h08, 4'h0, 4'h0);
    any_req = req[0];
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      any_req = any_req | req[0];
    end
    checkOutput("ch0_held_in_setup", 32'(any_req), 32'(0));
    mode[0] = M_ECHO;
    waitDone();

    $display("[TB] channel 0 ack stuck high past timeout");
    mode[0] = M_ONE;
    waitCycles(3);
    applyStimulus(16'h8001, 4'hF, 6'h01, 6'h00, 6'h08, 4'b0001, 4'b0000);
    waitDone();
    checkOutput("ch_err_sticky", 32'(ch_err), 32'(4'b0001));
    mode[0] = M_ECHO;
    waitCycles(3);

    $display("[TB] reset during chunk 2");
    for (int g = 0; g < N; g++) rise_cnt[g] = 0;
    applyStimulus(16'hBEEF, 4'hF, 6'h2F, 6'h3B, 6'h0B, 4'h0, 4'h0);
    checkOutput("ch_err_cleared_on_accept", 32'(ch_err), 32'(0));
    t = 0;
    while (rise_cnt[0] < 3 && t < 500) begin
      @(negedge clk);
      t++;
    end
    checkOutput("reached_chunk2", 32'(rise_cnt[0]), 32'(3));
    @(negedge clk);
    rst = 1'b1;
    #1;
    checkOutput("abort_req", 32'(req), 32'(0));
    checkOutput("abort_busy", 32'(busy), 32'(0));
    checkOutput("abort_in_ready", 32'(bus.in_ready), 32'(0));
    for (int g = 0; g < N; g++) exp_q[g].delete();
    done_q.delete();
    waitCycles(3);
    rst = 1'b0;
    #1;
    checkOutput("in_ready_after_abort", 32'(bus.in_ready), 32'(1));
    applyStimulus(16'h5A5A, 4'hF, 6'h1A, 6'h29, 6'h05, 4'h0, 4'h0);
    waitDone();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
